parking_floor_allocator: RTL
============================

// Module: parking_floor_allocator
// PURPOSE
//  Entry-side occupancy tracker for the parking system. Keeps a per-floor car count,
//  picks the lowest floor with a free spot, and drives the floor/full pair consumed
//  by the one-hot floor indicator stage. Runs the entry-gate handshake and processes
//  exits. Sits between the gate sensors and the floor display logic.
// PARAMETERS
//  NUM_FLOORS      3   floors served (1..3; code 2'b11 is reserved for "none")
//  SPOTS_PER_FLOOR 4   capacity of each floor (>=1)
//  GATE_CYCLES     8   cycles gate_open stays high per accepted entry (>=1)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   synchronous, active-high reset
//  entry_req   in   1   car waiting at entry gate (level, sampled each cycle)
//  exit_req    in   1   car leaving this cycle (1-cycle pulse)
//  exit_floor  in   2   floor the exiting car came from, valid with exit_req
//  floor       out  2   lowest floor with a free spot; 2'b11 when full
//  full        out  1   all floors at capacity
//  entry_ack   out  1   1-cycle pulse: entry accepted, car counted on 'floor'
//  gate_open   out  1   entry barrier command
//  exit_err    out  1   1-cycle pulse: illegal exit (empty or invalid floor)
//  occupancy   out  OCC_W total cars parked, OCC_W=$clog2(NUM_FLOORS*SPOTS_PER_FLOOR+1)
// BEHAVIOUR
//  - Reset: all counts 0, FSM IDLE, gate_open=0, entry_ack=0, exit_err=0,
//    occupancy=0; hence floor=0, full=0 in the cycle after reset.
//  - floor/full/occupancy: combinational from count registers only (no path from
//    inputs); reflect a count update the cycle after the update edge.
//  - full = every count == SPOTS_PER_FLOOR. floor = lowest index i with
//    count[i] < SPOTS_PER_FLOOR; 2'b11 when full.
//  - FSM states: IDLE, OPEN.
//    IDLE: entry_req && !full -> entry_ack=1 this cycle (comb from state/inputs),
//      count[floor]++ at the edge, load gate timer = GATE_CYCLES-1, go OPEN.
//      entry_req && full -> no ack, no change, stay IDLE (car waits).
//    OPEN: gate_open=1; timer decrements each cycle; at timer==0 go IDLE.
//      entry_req ignored in OPEN (one car per gate cycle). gate_open is a
//      registered Moore output: high for exactly GATE_CYCLES cycles.
//  - Exit (any state): exit_req with exit_floor < NUM_FLOORS and count>0 ->
//    count[exit_floor]-- at the edge. exit_floor >= NUM_FLOORS or count==0 ->
//    exit_err registered pulse next cycle, no count change.
//  - Simultaneous accepted entry and legal exit: both applied; same floor nets zero.
//    Allocation uses pre-update counts (exit does not free a spot for the same-cycle entry).
//  - Exit while full: full drops next cycle; a waiting entry_req is accepted then.
//  - Counts never exceed SPOTS_PER_FLOOR nor go below 0 (guarded, not saturated silently).
//  - rst mid-OPEN: gate_open=0 next cycle, all counts cleared.
// STRUCTURE
//  - Package parking_pkg: floor_t (logic [1:0]), FLOOR_NONE = 2'b11,
//    gate_state_t enum {IDLE, OPEN}, default NUM_FLOORS / SPOTS_PER_FLOOR.
//  - Sub-module parking_floor_counter (one per floor, generate loop): inc, dec
//    inputs, count out, at_cap out, underflow-guard err out.
//  - Top: priority encoder for floor, AND of at_cap for full, adder for occupancy,
//    gate FSM + timer.
// TESTING (NUM_FLOORS=3, SPOTS_PER_FLOOR=2, GATE_CYCLES=3)
//  - Reset: hold rst 2 cycles -> floor=0, full=0, occupancy=0, gate_open=0.
//  - Fill: entry_req held high -> acks allocate floors 0,0,1,1,2,2; each ack followed
//    by gate_open 3 cycles; after 6th: full=1, floor=2'b11, further entry_req no ack.
//  - Exit while full: exit_req, exit_floor=1 -> next cycle full=0, floor=1;
//    held entry_req acked, occupancy back to 6.
//  - Illegal exit: empty system, exit_req exit_floor=2 -> exit_err=1 one cycle,
//    occupancy stays 0; exit_floor=3 -> exit_err=1.
//  - Simultaneous: count[0]=1, IDLE, entry_req and exit_req exit_floor=0 same cycle
//    -> entry_ack=1, count[0] stays 1, occupancy unchanged.
//  - Reset mid-gate: assert rst on 2nd OPEN cycle -> gate_open=0 and occupancy=0 next cycle.

Source files
------------

// File: rtl/parking_floor_allocator_pkg.sv
// parking_pkg: shared floor type, "no floor" code, gate FSM states and default sizing
package parking_pkg;
  typedef logic [1:0] floor_t;
  localparam floor_t FLOOR_NONE = 2'b11;
  typedef enum logic {IDLE, OPEN} gate_state_t;
  localparam int NUM_FLOORS_DEF = 3;
  localparam int SPOTS_PER_FLOOR_DEF = 4;
  localparam int GATE_CYCLES_DEF = 8;
endpackage

// File: rtl/parking_floor_allocator_if.sv
// parking_floor_allocator_if: gate-sensor inputs and floor/gate outputs; master drives requests, slave is the allocator
interface parking_floor_allocator_if #(parameter int OCC_W = 4);
  import parking_pkg::*;
  logic entry_req;
  logic exit_req;
  floor_t exit_floor;
  floor_t floor;
  logic full;
  logic entry_ack;
  logic gate_open;
  logic exit_err;
  logic [OCC_W-1:0] occupancy;
  modport master(output entry_req, exit_req, exit_floor,
                 input floor, full, entry_ack, gate_open, exit_err, occupancy);
  modport slave(input entry_req, exit_req, exit_floor,
                output floor, full, entry_ack, gate_open, exit_err, occupancy);
endinterface

// File: rtl/parking_floor_allocator_counter.sv
// parking_floor_counter: per-floor car count with capacity/underflow guards (inc_i/dec_i in, count_o/at_cap_o/err_o out)
module parking_floor_counter #(
  parameter int SPOTS = 4,
  parameter int CW = $clog2(SPOTS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          at_cap_o,
  output logic          err_o
);
  logic [CW-1:0] count_q;
  assign count_o  = count_q;
  assign at_cap_o = count_q == CW'(SPOTS);
  assign err_o    = dec_i && count_q == '0;
  always_ff @(posedge clk)
    if (rst) count_q <= '0;
    else count_q <= count_q + CW'(inc_i && !at_cap_o) - CW'(dec_i && count_q != '0);
endmodule

// File: rtl/parking_floor_allocator.sv
// parking_floor_allocator: per-floor occupancy, lowest-free-floor pick, entry gate FSM and exit checking (clk/rst plus bus slave port)
module parking_floor_allocator
  import parking_pkg::*;
#(
  parameter int NUM_FLOORS      = NUM_FLOORS_DEF,
  parameter int SPOTS_PER_FLOOR = SPOTS_PER_FLOOR_DEF,
  parameter int GATE_CYCLES     = GATE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  parking_floor_allocator_if.slave bus
);
  localparam int CW    = $clog2(SPOTS_PER_FLOOR + 1);
  localparam int OCC_W = $clog2(NUM_FLOORS * SPOTS_PER_FLOOR + 1);
  localparam int TW    = GATE_CYCLES > 1 ? $clog2(GATE_CYCLES) : 1;
  logic [CW-1:0] cnt [NUM_FLOORS];
  logic [NUM_FLOORS-1:0] at_cap, cnt_err, inc, dec;
  gate_state_t state_q;
  logic [TW-1:0] timer_q;
  logic gate_open_q, exit_err_q;
  floor_t floor;
  logic [OCC_W-1:0] occ;
  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_floor
    assign inc[i] = bus.entry_ack && floor == floor_t'(i);
    assign dec[i] = bus.exit_req && bus.exit_floor == floor_t'(i);
    parking_floor_counter #(.SPOTS(SPOTS_PER_FLOOR)) u_cnt (
      .clk(clk), .rst(rst), .inc_i(inc[i]), .dec_i(dec[i]),
      .count_o(cnt[i]), .at_cap_o(at_cap[i]), .err_o(cnt_err[i])
    );
  end
  // Scan from the top floor down so the lowest non-full floor wins.
  always_comb begin
    floor = FLOOR_NONE;
    occ   = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      floor = at_cap[i] ? floor : floor_t'(i);
      occ   = occ + OCC_W'(cnt[i]);
    end
  end
  assign bus.floor     = floor;
  assign bus.full      = &at_cap;
  assign bus.occupancy = occ;
  assign bus.entry_ack = !rst && state_q == IDLE && bus.entry_req && !bus.full;
  assign bus.gate_open = gate_open_q;
  assign bus.exit_err  = exit_err_q;
  always_ff @(posedge clk)
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      gate_open_q <= 1'b0;
      exit_err_q  <= 1'b0;
    end else begin
      // An exit is legal only if it decodes to a real floor that holds a car.
      exit_err_q <= bus.exit_req && !(|(dec & ~cnt_err));
      if (state_q == IDLE) begin
        if (bus.entry_ack) begin
          state_q     <= OPEN;
          timer_q     <= TW'(GATE_CYCLES - 1);
          gate_open_q <= 1'b1;
        end
      end else begin
        timer_q <= timer_q - TW'(1);
        if (timer_q == '0) begin
          state_q     <= IDLE;
          gate_open_q <= 1'b0;
        end
      end
    end
endmodule
